// File: rtl/reset_preset_sequencer.sv
// Sequences active-low reset/preset strobes: async assert, synchronized release plus HOLD_CYCLES hold, timed preset pulses.
// Outputs registered (1 cycle after the deciding edge); optional pending preset request when RSTSEQ_REQ_QUEUE_EN is defined.
module reset_preset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int PRESET_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_rst_req,
  input  logic preset_req,
  output logic rst_n_o,
  output logic preset_n_o,
  output logic preset_ack,
  output logic rst_done,
  output logic busy
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_IDLE   = 3'd3;
  localparam logic [2:0] ST_PRESET = 3'd4;

  localparam int MAX_CYC = (HOLD_CYCLES > PRESET_CYCLES) ? HOLD_CYCLES : PRESET_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PRESET_LOAD = CW'(PRESET_CYCLES - 1);

  logic [2:0]             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pending;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RESET, ST_SYNC: begin
        // Move on at the same edge that shifts a 1 into the last stage.
        if (sync_q[SYNC_STAGES-2]) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          state_nxt = ST_SYNC;
        end
      end
      ST_HOLD: begin
        if (sw_rst_req) begin
          cnt_nxt = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_IDLE: begin
        if (sw_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else if (preset_req || pending) begin
          state_nxt = ST_PRESET;
          cnt_nxt   = PRESET_LOAD;
        end
      end
      ST_PRESET: begin
        if (sw_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef RSTSEQ_REQ_QUEUE_EN
  logic pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (sw_rst_req && pending) begin
      pending_nxt = 1'b0;
    end else if (preset_req && (state != ST_IDLE || sw_rst_req)) begin
      pending_nxt = 1'b1;
    end else if (state == ST_IDLE && state_nxt == ST_PRESET) begin
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= pending_nxt;
    end
  end
`else
  assign pending = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESET;
      cnt        <= '0;
      sync_q     <= '0;
      rst_n_o    <= 1'b0;
      preset_n_o <= 1'b1;
      preset_ack <= 1'b0;
      rst_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      // Both strobes decode from the same next state, so they can never be low together.
      rst_n_o    <= (state_nxt == ST_IDLE) || (state_nxt == ST_PRESET);
      preset_n_o <= (state_nxt != ST_PRESET);
      preset_ack <= (state == ST_PRESET) && (state_nxt == ST_IDLE);
      rst_done   <= (state == ST_HOLD) && (state_nxt == ST_IDLE);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
